booth_mult_seq: RTL and testbench

Sequential radix-2 Booth multiplier, parametrised in operand width, with selectable signed or unsigned mode. It is the iterative datapath block of the Booth Algorithm design. It replaces the hand-wired gate-level partial-product logic with one add/subtract/shift step per clock, and provides a start/done handshake for the surrounding controller.

---
 rtl/booth_pkg.sv | 10 +
 rtl/booth_mult_seq_if.sv | 26 ++
 rtl/booth_addsub.sv | 13 +
 rtl/booth_mult_seq.sv | 97 +++++++++
 tb/tb_booth_mult_seq.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared constants for the sequential Booth multiplier: FSM encoding and default width.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/done handshake and operand/result bus of the sequential Booth multiplier.
interface booth_mult_seq_if
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/booth_addsub.sv
// N-bit modulo adder/subtractor used by the Booth step; carry-out is dropped.
module booth_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one add/sub/shift step per clock, signed or unsigned.
// state | meaning
// IDLE  | waiting for start
// RUN   | one Booth step per cycle, cnt steps remaining
// DONE  | product valid for one cycle; start here re-launches immediately
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  booth_mult_seq_if.slave  bus
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);

  logic [1:0]         state_q, state_d;
  logic [N-1:0]       acc_q, q_q, m_q;
  logic               q_m1_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] product_q;

  logic               accept, last_step;
  logic [N-1:0]       sum, acc_new, acc_sh, q_sh, m_ext, q_ext;

  assign accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step = (state_q == RUN) && (cnt_q == CW'(1));

  // One extra operand bit lets the signed datapath also handle unsigned operands exactly.
  assign m_ext = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
  assign q_ext = {bus.signed_mode & bus.multiplier[WIDTH-1], bus.multiplier};

  booth_addsub #(.N(N)) u_addsub (
    .a   (acc_q),
    .b   (m_q),
    .sub (q_q[0]),
    .y   (sum)
  );

  assign acc_new = (q_q[0] ^ q_m1_q) ? sum : acc_q;
  assign acc_sh  = {acc_new[N-1], acc_new[N-1:1]};
  assign q_sh    = {acc_new[0], q_q[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = last_step ? DONE : RUN;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      q_q       <= '0;
      q_m1_q    <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      acc_q  <= '0;
      q_q    <= q_ext;
      q_m1_q <= 1'b0;
      m_q    <= m_ext;
      cnt_q  <= CW'(N);
    end else if (state_q == RUN) begin
      acc_q  <= acc_sh;
      q_q    <= q_sh;
      q_m1_q <= q_q[0];
      cnt_q  <= cnt_q - CW'(1);
      // The 2N-bit internal product always fits in its low 2*WIDTH bits.
      if (last_step) product_q <= {acc_sh[N-3:0], q_sh};
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomized checks of booth_mult_seq at WIDTH=8 and WIDTH=16.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(8))  bus8 ();
  booth_mult_seq_if #(.WIDTH(16)) bus16 ();

  booth_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  booth_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] last8 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input int w, input bit sm,
                                           input logic [15:0] a, input logic [15:0] b);
    longint ea, eb, p, mask;
    ea = longint'(a);
    eb = longint'(b);
    if (sm && a[w-1]) ea = ea - (longint'(1) << w);
    if (sm && b[w-1]) eb = eb - (longint'(1) << w);
    p    = ea * eb;
    mask = (longint'(1) << (2 * w)) - 1;
    return 32'(p & mask);
  endfunction

  // One operation on the 8-bit unit with full timing checks; optional re-pulse of start mid-run.
  task automatic op8(input string tag, input bit sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input bit repulse);
    int lat, nb;
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = sm; bus8.multiplicand = a; bus8.multiplier = b;
    @(negedge clk);
    bus8.start = 1'b0; bus8.signed_mode = ~sm; bus8.multiplicand = ~a; bus8.multiplier = ~b;
    lat = 0;
    nb  = 0;
    while (!bus8.done && lat < 30) begin
      if (bus8.busy) nb++;
      if (lat == 1) chk({tag, "_hold"}, 32'(bus8.product), 32'(last8));
      if (repulse && lat == 2) begin
        bus8.start = 1'b1; bus8.multiplicand = 8'h11; bus8.multiplier = 8'h22;
      end
      if (repulse && lat == 3) bus8.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_busy_cyc"}, 32'(nb), 32'd9);
    chk({tag, "_prod"}, 32'(bus8.product), 32'(exp));
    chk({tag, "_busy_done"}, 32'(bus8.busy), 32'd0);
    last8 = exp;
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(bus8.done), 32'd0);
    chk({tag, "_prod_keep"}, 32'(bus8.product), 32'(exp));
  endtask

  task automatic rnd8(input int iters);
    int lat;
    bit sm;
    logic [7:0] a, b;
    logic [31:0] e;
    for (int i = 0; i < iters; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = 8'($urandom);
      e  = ref_prod(8, sm, {8'h00, a}, {8'h00, b});
      @(negedge clk);
      bus8.start = 1'b1; bus8.signed_mode = sm; bus8.multiplicand = a; bus8.multiplier = b;
      @(negedge clk);
      bus8.start = 1'b0;
      lat = 0;
      while (!bus8.done && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("rnd8_lat", 32'(lat), 32'd9);
      chk("rnd8_prod", 32'(bus8.product), e);
    end
  endtask

  task automatic rnd16(input int iters);
    int lat;
    bit sm;
    logic [15:0] a, b;
    logic [31:0] e;
    for (int i = 0; i < iters; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i == 0) begin a = 16'h8000; b = 16'h8000; end
      if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
      e  = ref_prod(16, sm, a, b);
      @(negedge clk);
      bus16.start = 1'b1; bus16.signed_mode = sm; bus16.multiplicand = a; bus16.multiplier = b;
      @(negedge clk);
      bus16.start = 1'b0;
      lat = 0;
      while (!bus16.done && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      chk("rnd16_lat", 32'(lat), 32'd17);
      chk("rnd16_prod", 32'(bus16.product), e);
    end
  endtask

  logic [7:0]  b2b_a   [3] = '{8'h10, 8'h80, 8'hFF};
  logic [7:0]  b2b_b   [3] = '{8'h10, 8'h7F, 8'h02};
  bit          b2b_sm  [3] = '{1'b0, 1'b1, 1'b0};
  logic [15:0] b2b_exp [3] = '{16'h0100, 16'hC080, 16'h01FE};

  initial begin
    int lat;
    bus8.start = 1'b0;  bus8.signed_mode = 1'b0;  bus8.multiplicand = '0;  bus8.multiplier = '0;
    bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.multiplicand = '0; bus16.multiplier = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_prod", 32'(bus8.product), 32'd0);
    rst = 1'b0;

    op8("s3xm4",    1'b1, 8'h03, 8'hFC, 16'hFFF4, 1'b0);
    op8("u255sq",   1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    op8("sm1sq",    1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
    op8("sm128sq",  1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
    op8("s0x7f",    1'b1, 8'h00, 8'h7F, 16'h0000, 1'b0);
    op8("s7fxm128", 1'b1, 8'h7F, 8'h80, 16'hC080, 1'b0);
    op8("repulse",  1'b1, 8'h03, 8'hFC, 16'hFFF4, 1'b1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = 1'b0; bus8.multiplicand = 8'h55; bus8.multiplier = 8'h33;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus8.busy), 32'd0);
    chk("arst_done", 32'(bus8.done), 32'd0);
    chk("arst_prod", 32'(bus8.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last8 = '0;
    op8("u5x7", 1'b0, 8'h05, 8'h07, 16'h0023, 1'b0);

    // Start held high: each accept in DONE samples the operands then present.
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = b2b_sm[0];
    bus8.multiplicand = b2b_a[0]; bus8.multiplier = b2b_b[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus8.signed_mode = ~b2b_sm[k]; bus8.multiplicand = 8'hA5; bus8.multiplier = 8'h5A;
      lat = 0;
      while (!bus8.done && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_lat", 32'(lat), 32'd9);
      chk("b2b_prod", 32'(bus8.product), 32'(b2b_exp[k]));
      if (k < 2) begin
        bus8.signed_mode = b2b_sm[k+1];
        bus8.multiplicand = b2b_a[k+1]; bus8.multiplier = b2b_b[k+1];
      end else begin
        bus8.start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end_done", 32'(bus8.done), 32'd0);
    chk("b2b_end_busy", 32'(bus8.busy), 32'd0);

    rnd8(1000);
    rnd16(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
